// File: rtl/range_sequence_sender_if.sv
// Load/start/framed-output bundle for range_sequence_sender.
// RANGE_SENDER_EXPECT_EN adds the expected_range/expected_valid outputs.
`timescale 1ns/1ps
interface range_sequence_sender_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             busy;
    logic             done;
    logic             full;
    logic [CW-1:0]    count;
    logic             err_short;
`ifdef RANGE_SENDER_EXPECT_EN
    logic [WIDTH-1:0] expected_range;
    logic             expected_valid;
`endif

    modport slave (
        input  wr_en, wr_data, start,
        output data_out, go, finish, busy, done, full, count, err_short
`ifdef RANGE_SENDER_EXPECT_EN
        , output expected_range, expected_valid
`endif
    );

    modport master (
        output wr_en, wr_data, start,
        input  data_out, go, finish, busy, done, full, count, err_short
`ifdef RANGE_SENDER_EXPECT_EN
        , input expected_range, expected_valid
`endif
    );
endinterface

// File: rtl/range_sequence_sender.sv
// Buffers up to DEPTH samples and replays them as one go/finish framed sequence.
// RANGE_SENDER_EXPECT_EN adds running max-min tracking of the loaded samples.
`timescale 1ns/1ps
module range_sequence_sender #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    range_sequence_sender_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_q;
    logic             go_q;
    logic             finish_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             full_s;
    logic             wr_ok_s;
    logic [IW-1:0]    idx_d;
    logic             last_s;
    logic             next_last_s;

    assign full_s      = (count_q == CW'(DEPTH));
    assign wr_ok_s     = (state_q == ST_IDLE) && !bus.start && bus.wr_en && !full_s;
    assign idx_d       = idx_q + IW'(1'b1);
    // idx_d only matters while idx_q is not the last slot, so it never wraps in use.
    assign last_s      = (CW'(idx_q) == count_q - CW'(1'b1));
    assign next_last_s = (CW'(idx_d) == count_q - CW'(1'b1));

`ifdef RANGE_SENDER_EXPECT_EN
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;
    logic             seen_q;

    assign bus.expected_range = max_q - min_q;
    assign bus.expected_valid = done_q;
`endif

    // Sequencer: loading, framed replay and the single-cycle completion state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef RANGE_SENDER_EXPECT_EN
            max_q  <= '0;
            min_q  <= '0;
            seen_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (bus.start) begin
                        if (count_q >= CW'(2'd2)) begin
                            state_q  <= ST_SEND;
                            idx_q    <= '0;
                            data_q   <= mem_q[0];
                            go_q     <= 1'b1;
                            finish_q <= 1'b0;
                            busy_q   <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (wr_ok_s) begin
                        mem_q[count_q[IW-1:0]] <= bus.wr_data;
                        count_q                <= count_q + CW'(1'b1);
`ifdef RANGE_SENDER_EXPECT_EN
                        seen_q <= 1'b1;
                        if (!seen_q || bus.wr_data > max_q) begin
                            max_q <= bus.wr_data;
                        end else begin
                            max_q <= max_q;
                        end
                        if (!seen_q || bus.wr_data < min_q) begin
                            min_q <= bus.wr_data;
                        end else begin
                            min_q <= min_q;
                        end
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (last_s) begin
                        state_q  <= ST_DONE;
                        data_q   <= '0;
                        go_q     <= 1'b0;
                        finish_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        count_q  <= '0;
                    end else begin
                        idx_q    <= idx_d;
                        data_q   <= mem_q[idx_d];
                        go_q     <= 1'b0;
                        finish_q <= next_last_s;
                    end
                end
                ST_DONE: begin
                    // Tracking survives the done cycle so expected_range is valid alongside done.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
`ifdef RANGE_SENDER_EXPECT_EN
                    max_q  <= '0;
                    min_q  <= '0;
                    seen_q <= 1'b0;
`endif
                end
                default: begin
                    state_q  <= ST_IDLE;
                    data_q   <= '0;
                    go_q     <= 1'b0;
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.go        = go_q;
    assign bus.finish    = finish_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_short = err_q;
    assign bus.count     = count_q;
    assign bus.full      = full_s;
endmodule

// File: doc/range_sequence_sender.md
Name: range_sequence_sender

Overview:
- Transmit-side counterpart of the range finder's go/data/finish input protocol.
- Software or a bench loads up to DEPTH samples through a write port; on `start`, the block replays them as one framed sequence, one sample per cycle.
- Framing: `go` on the first sample, `finish` on the last sample, `go` and `finish` never high together.
- Used as a stimulus source and loopback driver in front of range-finding datapaths.

Parameters:
- WIDTH, 16, sample width in bits.
- DEPTH, 8, sample buffer capacity in words; must be ≥ 2.

Ports:
- clock  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write `wr_data` into the next free buffer slot.
- wr_data  input  WIDTH  sample to load.
- start  input  1  request transmission of the loaded samples.
- data_out  output  WIDTH  sample being transmitted.
- go  output  1  high only on the first transmitted sample.
- finish  output  1  high only on the last transmitted sample.
- busy  output  1  high while transmitting.
- done  output  1  one-cycle pulse after the `finish` cycle.
- full  output  1  buffer holds DEPTH samples.
- count  output  $clog2(DEPTH+1)  number of samples loaded.
- err_short  output  1  one-cycle pulse when `start` is seen with `count` < 2.

Behaviour:
- Reset (asynchronous): state IDLE; `count` = 0; read index = 0.
  - Outputs: `data_out` = 0, `go` = 0, `finish` = 0, `busy` = 0, `done` = 0, `err_short` = 0, `full` = 0.
  - Buffer contents are don't-care.
- States:
  - IDLE: loading allowed.
  - SEND: one sample per cycle.
  - DONE: single cycle.
- IDLE, loading:
  - `wr_en` with `count` < DEPTH: writes `buf[count]`; `count` increments at the edge.
  - `wr_en` with `full`: the write is dropped; no state change.
- IDLE, `start`:
  - `count` ≥ 2: go to SEND with read index 0.
  - `count` < 2: stay in IDLE; assert `err_short` for the next cycle; buffer and `count` are untouched.
- `start` and `wr_en` in the same IDLE cycle: `start` has priority and the write is dropped.
- SEND outputs are registered; the first SEND cycle begins one clock after the `start` edge.
  - `busy` = 1 and `data_out` = `buf[idx]`.
  - `go` = (`idx` == 0); `finish` = (`idx` == `count`−1).
  - `idx` increments each cycle; after the `finish` cycle, go to DONE.
  - Sequence length is exactly `count` cycles.
- DONE:
  - `done` = 1, `busy` = 0, `data_out` = 0, `go` = `finish` = 0.
  - `count` clears to 0, `full` clears; next state IDLE.
- `wr_en` and `start` are ignored in SEND and DONE.
- `go`/`finish` are never both 1. `data_out` is 0 whenever not in SEND.
- `full` = (`count` == DEPTH), combinational from `count`.
- Reset mid-SEND: outputs drop to 0 asynchronously; no `finish` or `done` is produced.

Optional Feature:
- Macro: RANGE_SENDER_EXPECT_EN.
- Defined:
  - Adds outputs `expected_range` (WIDTH) and `expected_valid` (1).
  - During loading, the block tracks the running unsigned max and min of accepted writes; the first write initialises both.
  - `expected_range` = max − min, unsigned, WIDTH bits, held through SEND.
  - `expected_valid` pulses together with `done`.
  - Tracked max/min clear on DONE and on reset.
- Not defined: these ports and the tracking logic do not exist.

Test Plan:
- Load 5, 9, 2, 7; `start` → next 4 cycles `data_out` = 5, 9, 2, 7; `go` high on the 5 cycle only; `finish` high on the 7 cycle only; then `done` pulses once, `count` = 0. With RANGE_SENDER_EXPECT_EN: `expected_range` = 7.
- Load 1 sample (0x1234); `start` → `err_short` pulses one cycle; no `go`; `count` stays 1.
- Load DEPTH = 8 samples, then 9th write 0xFFFF → `full` = 1, `count` = 8. `start` → 8-cycle sequence without 0xFFFF; the `finish` cycle carries sample 8.
- Load 2 samples (0xAAAA, 0x5555) → `go` cycle data 0xAAAA, `finish` cycle data 0x5555 on the immediately following cycle.
- Pulse `start` and `wr_en` during SEND → both ignored; sequence unchanged; no extra samples next frame.
- Assert `reset` on the 2nd SEND cycle of a 4-sample frame → `go`/`finish`/`busy`/`data_out` are 0 immediately; `count` = 0; no `done` after release.
